// File: rtl/rv32i_fetch_ctrl.sv
// rv32i_fetch_ctrl: rv32i instruction fetch sequencer with single-outstanding memory request and 2-entry {pc,inst} queue
// ports: i_clk/i_rst (sync, active-high); o_iaddr/o_stb_inst/i_ack_inst/i_inst memory side;
//        o_inst/o_pc/o_ce/i_stall fetch-stage side; i_redirect/i_redirect_pc branch/jump/trap redirect
module rv32i_fetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_iaddr,
  output logic        o_stb_inst,
  input  logic        i_ack_inst,
  input  logic [31:0] i_inst,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_ce,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
);
  typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;
  state_t state;
  logic [31:0] pc, b_pc, b_inst, tgt, iaddr_nx;
  logic [1:0] cnt, cnt_n, slot;
  logic ack, pop, push;
  // head entry lives directly in o_pc/o_inst; b_* is the second entry
  always_comb begin
    tgt = {i_redirect_pc[31:2], 2'b00};
    iaddr_nx = o_iaddr + 32'd4;
    ack = o_stb_inst & i_ack_inst;
    pop = o_ce & ~i_stall & ~i_redirect;
    push = ack & (state == WAIT) & ~i_redirect;
    slot = cnt - {1'b0, pop};
    cnt_n = i_redirect ? 2'd0 : slot + {1'b0, push};
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      pc <= PC_RESET;
      o_iaddr <= PC_RESET;
      o_stb_inst <= 1'b0;
      cnt <= 2'd0;
      o_ce <= 1'b0;
      o_inst <= 32'd0;
      o_pc <= PC_RESET;
      b_pc <= 32'd0;
      b_inst <= 32'd0;
    end else begin
      cnt <= cnt_n;
      o_ce <= cnt_n != 2'd0;
      if (pop) begin
        o_pc <= b_pc;
        o_inst <= b_inst;
      end
      // a push lands in the first free slot after this cycle's pop
      if (push && slot == 2'd0) begin
        o_pc <= o_iaddr;
        o_inst <= i_inst;
      end
      if (push && slot == 2'd1) begin
        b_pc <= o_iaddr;
        b_inst <= i_inst;
      end
      if (i_redirect) pc <= tgt;
      case (state)
        IDLE: if (!i_redirect && cnt != 2'd2) begin
          state <= WAIT;
          o_iaddr <= pc;
          o_stb_inst <= 1'b1;
        end
        WAIT: if (i_redirect) begin
          // an unacked request must still be drained before the target is fetched
          state <= ack ? IDLE : FLUSH;
          o_stb_inst <= ~ack;
        end else if (ack) begin
          pc <= iaddr_nx;
          if (cnt_n == 2'd2) begin
            state <= IDLE;
            o_stb_inst <= 1'b0;
          end else o_iaddr <= iaddr_nx;
        end
        FLUSH: if (ack) begin
          state <= IDLE;
          o_stb_inst <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32i_fetch_ctrl.sv
// tb_rv32i_fetch_ctrl: randomized bench for rv32i_fetch_ctrl against a queue-level fetch model
module tb_rv32i_fetch_ctrl;
  localparam logic [31:0] PCR = 32'hFFFF_FFF8;
  typedef struct packed {logic [31:0] pc; logic [31:0] inst;} ent_t;
  logic i_clk = 0, i_rst = 1, i_ack_inst = 0, i_stall = 0, i_redirect = 0;
  logic [31:0] i_inst = 0, i_redirect_pc = 0;
  logic o_stb_inst, o_ce;
  logic [31:0] o_iaddr, o_inst, o_pc;
  int checks = 0, errors = 0;
  ent_t q[$];
  logic [31:0] exp_pc = PCR;
  bit flushing = 0;
  int wait_cnt = 0;
  always #5 i_clk = ~i_clk;
  rv32i_fetch_ctrl #(.PC_RESET(PCR)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .o_iaddr(o_iaddr), .o_stb_inst(o_stb_inst),
    .i_ack_inst(i_ack_inst), .i_inst(i_inst), .o_inst(o_inst), .o_pc(o_pc), .o_ce(o_ce),
    .i_stall(i_stall), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc)
  );
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // one clock: memory answers after dly extra cycles of strobe; model tracks the fetch stream
  task automatic step(input bit rst, input bit rd, input logic [31:0] tgt, input bit st, input int dly, input bit stray);
    logic pre_stb;
    logic [31:0] pre_addr;
    bit acc, fl_pre;
    int pre_cnt, post;
    @(negedge i_clk);
    pre_stb = o_stb_inst;
    pre_addr = o_iaddr;
    acc = 0;
    if (pre_stb) begin
      if (wait_cnt >= dly) begin
        acc = 1;
        wait_cnt = 0;
      end else wait_cnt++;
    end else wait_cnt = 0;
    i_ack_inst = acc | (!pre_stb && stray && $urandom_range(1, 0) == 1);
    i_inst = acc ? mem_f(pre_addr) : $urandom;
    i_rst = rst;
    i_redirect = rd;
    i_redirect_pc = tgt;
    i_stall = st;
    @(posedge i_clk);
    #1;
    fl_pre = flushing;
    pre_cnt = q.size();
    if (rst) begin
      q.delete();
      flushing = 0;
      exp_pc = PCR;
      wait_cnt = 0;
      check("rst_stb", o_stb_inst, 0);
      check("rst_ce", o_ce, 0);
      check("rst_inst", o_inst, 0);
      check("rst_pc", o_pc, PCR);
      check("rst_iaddr", o_iaddr, PCR);
      return;
    end
    if (rd) begin
      q.delete();
      flushing = pre_stb && !acc;
      exp_pc = {tgt[31:2], 2'b00};
    end else begin
      if (pre_cnt != 0 && !st) void'(q.pop_front());
      if (acc) begin
        if (flushing) flushing = 0;
        else begin
          q.push_back({exp_pc, mem_f(exp_pc)});
          exp_pc += 32'd4;
        end
      end
    end
    post = q.size();
    check("ce", o_ce, post != 0);
    if (post != 0) begin
      check("pc", o_pc, q[0].pc);
      check("inst", o_inst, q[0].inst);
    end
    if (pre_stb && !acc) begin
      check("stb_hold", o_stb_inst, 1);
      check("addr_hold", o_iaddr, pre_addr);
    end
    if (!rd && !fl_pre && pre_cnt < 2 && post < 2) check("issue", o_stb_inst, 1);
    if (!rd && post == 2) check("full_idle", o_stb_inst, 0);
    if (o_stb_inst && !flushing) check("iaddr", o_iaddr, exp_pc);
  endtask
  initial begin
    logic [31:0] wrap_seq [3];
    bit found;
    wrap_seq[0] = 32'hFFFF_FFF8;
    wrap_seq[1] = 32'hFFFF_FFFC;
    wrap_seq[2] = 32'h0000_0000;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("first_stb", o_stb_inst, 1);
    check("first_iaddr", o_iaddr, PCR);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 0, 0, 0);
      check("stream_ce", o_ce, 1);
      check("stream_stb", o_stb_inst, 1);
      if (i < 3) check("wrap_pc", o_pc, wrap_seq[i]);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 0, 0);
      check("stall_stb", o_stb_inst, 0);
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 3, 0);
    for (int i = 0; i < 10 && !(o_stb_inst && wait_cnt == 0 && !flushing); i++) step(0, 0, 0, 0, 3, 0);
    step(0, 1, 32'h0000_0103, 0, 3, 0);
    check("redir_ce", o_ce, 0);
    check("redir_flush_stb", o_stb_inst, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0, 0, 3, 0);
      found = o_stb_inst && !flushing;
    end
    check("redir_found", found, 1);
    check("redir_addr", o_iaddr, 32'h0000_0100);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h0000_0200, 0, 0, 0);
    check("redir_ack_ce", o_ce, 0);
    check("redir_ack_stb", o_stb_inst, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("redir_tgt_ce", o_ce, 1);
    check("redir_tgt_pc", o_pc, 32'h0000_0200);
    for (int i = 0; i < 800; i++)
      step(0, $urandom_range(19, 0) == 0, $urandom, $urandom_range(2, 0) == 0, $urandom_range(3, 0), 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("rerun_stb", o_stb_inst, 1);
    check("rerun_iaddr", o_iaddr, PCR);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
